// File: rtl/rv32i_alu_regfile_unit_pkg.sv
// Shared width constants and ALU operation encoding for the RV32I execution slice.
// The control codes match the encoding produced by the core FSM.
package rv32i_defines;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;
endpackage

package alu_types;
    typedef enum logic [3:0] {
        ALU_INVALID = 4'b0000,
        ALU_AND     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ADD     = 4'b1000,
        ALU_SUB     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SLTU    = 4'b1111
    } alu_control_t;
endpackage

// File: rtl/rv32i_alu_regfile_unit_register.sv
// Generic N-bit enable register with asynchronous active-low reset.
// Used as one storage word per architectural register.
module register #(
    parameter int unsigned    N     = 32,
    parameter logic [N-1:0]   RESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rv32i_alu_regfile_unit.sv
// RV32I execution slice: 32x32 register file (x0 hardwired to zero, two async
// read ports, one clocked write port) and an independent combinational ALU.
module rv32i_alu_regfile_unit
    import rv32i_defines::*;
    import alu_types::*;
#(
    parameter logic [31:0] RF_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  control,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        equal
);

    logic [XLEN-1:0] w_regs [REG_COUNT];

    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_rf
        register #(
            .N     (XLEN),
            .RESET (RF_RESET)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .ena (wr_ena && (wr_addr == 5'(gi))),
            .d   (wr_data),
            .q   (w_regs[gi])
        );
    end

    // No write-through: a read of the register being written sees the old word.
    assign rd_data0 = w_regs[rd_addr0];
    assign rd_data1 = w_regs[rd_addr1];

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [4:0]  w_sh;
    logic [31:0] w_result;
    logic        w_overflow;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_sh   = b[4:0];

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (alu_control_t'(control))
            ALU_AND:  w_result = a & b;
            ALU_OR:   w_result = a | b;
            ALU_XOR:  w_result = a ^ b;
            ALU_SLL:  w_result = a << w_sh;
            ALU_SRL:  w_result = a >> w_sh;
            ALU_SRA:  w_result = $unsigned($signed(a) >>> w_sh);
            ALU_ADD: begin
                w_result   = w_sum;
                w_overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
            end
            ALU_SUB: begin
                w_result   = w_diff;
                w_overflow = (a[31] != b[31]) && (w_diff[31] != a[31]);
            end
            ALU_SLT:  w_result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: w_result = {31'b0, (a < b)};
            default: begin
                w_result   = '0;
                w_overflow = 1'b0;
            end
        endcase
    end

    assign result   = w_result;
    assign overflow = w_overflow;
    assign zero     = (w_result == '0);
    assign equal    = (a == b);

endmodule

// File: tb/tb_rv32i_alu_regfile_unit.sv
// Self-checking bench: array-level register model plus arithmetic ALU reference,
// compared every negedge, with literal expectations for the key corner cases.
`timescale 1ns/1ps
module tb_rv32i_alu_regfile_unit;

    logic        clk;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  control;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    logic        equal;

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          cmp_on = 1'b0;

    logic [31:0] model_rf [32];

    rv32i_alu_regfile_unit #(.RF_RESET(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .a        (a),
        .b        (b),
        .control  (control),
        .result   (result),
        .overflow (overflow),
        .zero     (zero),
        .equal    (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference ALU computed from plain integer arithmetic.
    function automatic void alu_ref(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic ov);
        longint      s;
        logic [63:0] ext;
        int unsigned sh;
        sh = y % 32;
        r  = 32'h0;
        ov = 1'b0;
        case (c)
            4'b0001: r = x & y;
            4'b0010: r = x | y;
            4'b0011: r = x ^ y;
            4'b0101: r = x << sh;
            4'b0110: r = x >> sh;
            4'b0111: begin
                ext = {{32{x[31]}}, x};
                ext = ext >> sh;
                r   = ext[31:0];
            end
            4'b1000: begin
                s  = longint'($signed(x)) + longint'($signed(y));
                r  = x + y;
                ov = (s != longint'($signed(r)));
            end
            4'b1100: begin
                s  = longint'($signed(x)) - longint'($signed(y));
                r  = x - y;
                ov = (s != longint'($signed(r)));
            end
            4'b1101: r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'b1111: r = (x < y) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] <= 32'h0;
        end else if (wr_ena && wr_addr != 5'd0) begin
            model_rf[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        logic [31:0] er;
        logic        eo;
        if (cmp_on) begin
            alu_ref(control, a, b, er, eo);
            chk("cyc_rd0", rd_data0, (rd_addr0 == 5'd0) ? 32'h0 : model_rf[rd_addr0]);
            chk("cyc_rd1", rd_data1, (rd_addr1 == 5'd0) ? 32'h0 : model_rf[rd_addr1]);
            chk("cyc_result", result, er);
            chk("cyc_overflow", {31'b0, overflow}, {31'b0, eo});
            chk("cyc_zero", {31'b0, zero}, {31'b0, (er == 32'h0)});
            chk("cyc_equal", {31'b0, equal}, {31'b0, (a == b)});
        end
    end

    task automatic alu_lit(input string name, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_r, input logic exp_ov);
        logic [31:0] mr;
        logic        mo;
        control = c;
        a       = x;
        b       = y;
        #1;
        chk({name, "_res"}, result, exp_r);
        chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ov});
        alu_ref(c, x, y, mr, mo);
        chk({name, "_model"}, mr, exp_r);
    endtask

    initial begin
        logic [31:0] corners [8];
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                    32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0020, 32'h5555_AAAA};

        rst = 1'b0; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0; a = '0; b = '0; control = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cmp_on = 1'b1;

        // 1: all registers zero, x0 write ignored
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            chk("init_rd0", rd_data0, 32'h0);
            chk("init_rd1", rd_data1, 32'h0);
        end
        @(posedge clk); #1;
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; rd_addr0 = 5'd0;
        @(posedge clk); #1;
        wr_ena = 1'b0;
        #1 chk("x0_zero", rd_data0, 32'h0);

        // 2: no bypass, visible after edge on both ports
        @(posedge clk); #1;
        wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678; rd_addr0 = 5'd5; rd_addr1 = 5'd5;
        #1 chk("x5_pre_edge", rd_data0, 32'h0);
        @(posedge clk); #1;
        wr_ena = 1'b0;
        chk("x5_post0", rd_data0, 32'h1234_5678);
        chk("x5_post1", rd_data1, 32'h1234_5678);

        // 3-5: ALU literal corners
        alu_lit("add_ovf", 4'b1000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
        alu_lit("sub_eq", 4'b1100, 32'h5, 32'h5, 32'h0, 1'b0);
        chk("sub_eq_zero", {31'b0, zero}, 32'h1);
        chk("sub_eq_equal", {31'b0, equal}, 32'h1);
        alu_lit("sub_ovf", 4'b1100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
        alu_lit("sra", 4'b0111, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0);
        alu_lit("srl", 4'b0110, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0);
        alu_lit("sll", 4'b0101, 32'h8000_0000, 32'h21, 32'h0, 1'b0);
        alu_lit("sra31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        alu_lit("sll0", 4'b0101, 32'h89AB_CDEF, 32'h0, 32'h89AB_CDEF, 1'b0);
        alu_lit("slt", 4'b1101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
        alu_lit("sltu", 4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        alu_lit("and", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        alu_lit("or", 4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        alu_lit("xor", 4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        alu_lit("invalid", 4'b0000, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0);
        chk("invalid_zero", {31'b0, zero}, 32'h1);
        chk("invalid_equal", {31'b0, equal}, 32'h1);
        alu_lit("unlisted", 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
        chk("unlisted_equal", {31'b0, equal}, 32'h0);

        // Randomized traffic, compared every cycle by the negedge process
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            wr_ena   = 1'($urandom);
            wr_addr  = 5'($urandom);
            wr_data  = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr1 = ($urandom_range(0, 3) == 0) ? rd_addr0 : 5'($urandom);
            control  = 4'($urandom);
            a        = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            b        = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
        end

        // 6: fill x1..x31 with i*3, then reset between edges
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            wr_ena = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 3);
        end
        @(posedge clk); #1;
        wr_ena = 1'b0; rd_addr0 = 5'd7; rd_addr1 = 5'd31;
        #1;
        chk("fill_x7", rd_data0, 32'd21);
        chk("fill_x31", rd_data1, 32'd93);
        rst = 1'b0;
        #1;
        chk("async_rst_x7", rd_data0, 32'h0);
        chk("async_rst_x31", rd_data1, 32'h0);
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE_F00D;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            chk("rst_rd0", rd_data0, 32'h0);
            chk("rst_rd1", rd_data1, 32'h0);
        end
        @(posedge clk); #1;
        wr_ena = 1'b0; rst = 1'b1; rd_addr0 = 5'd9;
        #1 chk("write_in_rst_ignored", rd_data0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        cmp_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
